// File: rtl/paddle_judge_pkg.sv
// Shared types and default parameters for the paddle button judge.
package paddle_judge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WINDOW  = 2'd1,
    SERVED  = 2'd2,
    LOCKOUT = 2'd3
  } paddle_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned LOCKOUT_CYCLES_DEF  = 8;
  localparam int unsigned CNT_W_DEF           = 4;

endpackage

// File: rtl/paddle_channel.sv
// One paddle side: synchronise, debounce and edge-detect the button, then judge
// each press against the ball sitting on this side's end LED.
module paddle_channel
  import paddle_judge_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic button_i,
  input  logic ball_at_i,
  output logic press_o,
  output logic hit_o,
  output logic miss_o
);

  logic             s1_q, s2_q;
  logic             deb_q, deb_dly_q;
  logic [CNT_W-1:0] deb_cnt_q;
  logic             press_q;
  logic             ball_dly_q;
  logic             ball_exit_c;
  paddle_state_e    state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;

  assign ball_exit_c = ball_dly_q & ~ball_at_i;

  // Input conditioning and all state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      deb_q      <= 1'b0;
      deb_dly_q  <= 1'b0;
      deb_cnt_q  <= '0;
      press_q    <= 1'b0;
      ball_dly_q <= 1'b0;
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      s1_q <= button_i;
      s2_q <= s1_q;
      if (s2_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_q     <= s2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + CNT_W'(1);
      end
      deb_dly_q  <= deb_q;
      press_q    <= deb_q & ~deb_dly_q;
      ball_dly_q <= ball_at_i;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  // Judge: at most one hit or miss per ball visit; early presses trigger a lockout.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_q && !ball_at_i) begin
          state_d    = LOCKOUT;
          lock_cnt_d = CNT_W'(LOCKOUT_CYCLES - 1);
        end else if (press_q) begin
          hit_d   = 1'b1;
          state_d = SERVED;
        end else if (ball_at_i) begin
          state_d = WINDOW;
        end
      end
      WINDOW: begin
        if (press_q) begin
          hit_d   = 1'b1;
          state_d = SERVED;
        end else if (ball_exit_c) begin
          miss_d  = 1'b1;
          state_d = IDLE;
        end
      end
      SERVED: begin
        if (!ball_at_i) begin
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (ball_exit_c) begin
          miss_d = 1'b1;
        end
        if (lock_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign press_o = press_q;
  assign hit_o   = hit_q;
  assign miss_o  = miss_q;

endmodule

// File: rtl/paddle_judge.sv
// Two independent paddle channels (left and right) feeding the score controller.
module paddle_judge
  import paddle_judge_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic button_L,
  input  logic button_R,
  input  logic ball_at_L,
  input  logic ball_at_R,
  output logic press_L,
  output logic press_R,
  output logic hit_L,
  output logic hit_R,
  output logic miss_L,
  output logic miss_R
);

  paddle_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_left (
    .clk      (clk),
    .reset    (reset),
    .button_i (button_L),
    .ball_at_i(ball_at_L),
    .press_o  (press_L),
    .hit_o    (hit_L),
    .miss_o   (miss_L)
  );

  paddle_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_right (
    .clk      (clk),
    .reset    (reset),
    .button_i (button_R),
    .ball_at_i(ball_at_R),
    .press_o  (press_R),
    .hit_o    (hit_R),
    .miss_o   (miss_R)
  );

endmodule

// File: tb/tb_paddle_judge.sv
// Directed bench for paddle_judge: every cycle's output vector is compared
// against hand-derived pulse positions.
module tb_paddle_judge;

  logic clk = 1'b0;
  logic reset;
  logic button_L, button_R, ball_at_L, ball_at_R;
  logic press_L, press_R, hit_L, hit_R, miss_L, miss_R;
  logic [5:0] outs;

  localparam logic [5:0] P_L = 6'b100000;
  localparam logic [5:0] P_R = 6'b010000;
  localparam logic [5:0] H_L = 6'b001000;
  localparam logic [5:0] H_R = 6'b000100;
  localparam logic [5:0] M_L = 6'b000010;
  localparam logic [5:0] NONE = 6'b000000;

  int n_checks = 0;
  int n_pass   = 0;

  paddle_judge dut (
    .clk      (clk),
    .reset    (reset),
    .button_L (button_L),
    .button_R (button_R),
    .ball_at_L(ball_at_L),
    .ball_at_R(ball_at_R),
    .press_L  (press_L),
    .press_R  (press_R),
    .hit_L    (hit_L),
    .hit_R    (hit_R),
    .miss_L   (miss_L),
    .miss_R   (miss_R)
  );

  always #5 clk = ~clk;

  assign outs = {press_L, press_R, hit_L, hit_R, miss_L, miss_R};

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s got={pL,pR,hL,hR,mL,mR}=%b exp=%b", tag, got, exp);
    else
      n_pass++;
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic step(input string tag, input int k, input logic [5:0] exp);
    @(posedge clk);
    #1;
    check($sformatf("%s_s%0d", tag, k), outs, exp);
  endtask

  initial begin
    reset = 1'b0; button_L = 1'b0; button_R = 1'b0; ball_at_L = 1'b0; ball_at_R = 1'b0;

    // Reset held with inputs toggling, then release.
    for (int k = 1; k <= 3; k++) begin
      button_L = k[0]; button_R = ~k[0]; ball_at_L = k[1]; ball_at_R = k[0];
      step("rst_hold", k, NONE);
    end
    reset = 1'b1; button_L = 1'b0; button_R = 1'b0; ball_at_L = 1'b0; ball_at_R = 1'b0;
    step("rst_release", 1, NONE);

    // 3-cycle glitch on the left button: no press.
    for (int k = 1; k <= 10; k++) begin
      button_L = (k <= 3);
      step("glitch", k, NONE);
    end

    // Held left button: a single press, 7th sample after assertion.
    for (int k = 1; k <= 30; k++) begin
      button_L = (k <= 20);
      step("hold", k, (k == 7) ? P_L : NONE);
    end

    // Right hit in window; second press in the same visit is ignored.
    for (int k = 1; k <= 32; k++) begin
      button_R  = (k <= 8) || (k >= 15 && k <= 24);
      ball_at_R = (k >= 4 && k <= 24);
      step("hit_r", k, (k == 7 || k == 21) ? P_R : (k == 8) ? H_R : NONE);
    end
    button_R = 1'b0; ball_at_R = 1'b0;

    // Left ball visit with no press: miss after the ball leaves.
    for (int k = 1; k <= 10; k++) begin
      ball_at_L = (k <= 6);
      step("miss_l", k, (k == 7) ? M_L : NONE);
    end

    // Early press -> lockout; exit during lockout misses; later press hits.
    for (int k = 1; k <= 38; k++) begin
      logic [5:0] e;
      button_L  = (k <= 4) || (k >= 9 && k <= 15) || (k >= 20 && k <= 30);
      ball_at_L = (k >= 10 && k <= 13) || (k >= 24 && k <= 30);
      e = NONE;
      if (k == 7 || k == 15 || k == 26) e = P_L;
      if (k == 14) e = M_L;
      if (k == 27) e = H_L;
      step("lockout", k, e);
    end
    button_L = 1'b0; ball_at_L = 1'b0;

    // Press and ball exit on the same cycle on both sides: hits only.
    for (int k = 1; k <= 18; k++) begin
      button_L  = (k <= 10); button_R  = (k <= 10);
      ball_at_L = (k <= 7);  ball_at_R = (k <= 7);
      step("both", k, (k == 7) ? (P_L | P_R) : (k == 8) ? (H_L | H_R) : NONE);
    end
    button_L = 1'b0; button_R = 1'b0; ball_at_L = 1'b0; ball_at_R = 1'b0;

    // Mid-debounce reset restarts the synchroniser and debounce.
    for (int k = 1; k <= 28; k++) begin
      reset    = (k != 5);
      button_L = (k <= 20);
      step("midrst", k, (k == 12) ? P_L : NONE);
    end
    reset = 1'b1; button_L = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
